// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the regfile writeback scheduler.
// XLEN is the datapath width (32).
package rf_sched_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr selects the favoured side under contention
// and flips to the loser whenever advance is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates EX/MEM writebacks onto the single regfile write port and tracks busy registers.
// Optional RF_BYPASS_EN forwards the write-stage value to operands and relaxes RAW stalls.
module rf_wb_scheduler
    import rf_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_we,
    output logic              iss_stall,
    input  logic              wb0_valid,
    input  logic [REG_AW-1:0] wb0_waddr,
    input  logic [XLEN-1:0]   wb0_wdata,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [REG_AW-1:0] wb1_waddr,
    input  logic [XLEN-1:0]   wb1_wdata,
    output logic              wb1_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    output logic [XLEN-1:0]   op_rdata1,
    output logic [XLEN-1:0]   op_rdata2
);

    wb_req_t           w_req0, w_req1, w_win;
    wb_src_e           w_src;
    logic [1:0]        w_gnt;
    logic              w_rr_ptr;
    logic              w_iss_fire, w_haz1, w_haz2;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic [NREG-1:0]   r_busy, w_busy_set, w_busy_clr, w_busy_d;

    assign w_req0 = {wb0_valid, wb0_waddr, wb0_wdata};
    assign w_req1 = {wb1_valid, wb1_waddr, wb1_wdata};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({w_req1.valid, w_req0.valid}),
        .advance (w_req0.valid && w_req1.valid),
        .gnt     (w_gnt),
        .ptr     (w_rr_ptr)
    );

    assign wb0_ready = w_gnt[0];
    assign wb1_ready = w_gnt[1];

    always_comb begin
        w_src = WB_SRC_EX;
        if (w_req0.valid && w_req1.valid) begin
            w_src = wb_src_e'(w_rr_ptr);
        end else if (w_req1.valid) begin
            w_src = WB_SRC_MEM;
        end
    end

    assign w_win = (w_src == WB_SRC_MEM) ? w_req1 : w_req0;

    // Writes to x0 are consumed here so the regfile never sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_win.valid && (w_win.waddr != ZERO_REG);
            if (w_win.valid) begin
                r_rf_waddr <= w_win.waddr;
                r_rf_wdata <= w_win.wdata;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    assign w_iss_fire = iss_valid && !iss_stall && iss_we && (iss_rd != ZERO_REG);

    // A new producer issued alongside a commit to the same register keeps it busy.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (w_iss_fire) w_busy_set[iss_rd] = 1'b1;
        if (r_rf_we)    w_busy_clr[r_rf_waddr] = 1'b1;
        w_busy_d    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

`ifdef RF_BYPASS_EN
    logic w_byp1, w_byp2;

    assign w_byp1    = r_rf_we && (r_rf_waddr == iss_rs1) && (iss_rs1 != ZERO_REG);
    assign w_byp2    = r_rf_we && (r_rf_waddr == iss_rs2) && (iss_rs2 != ZERO_REG);
    assign w_haz1    = (iss_rs1 != ZERO_REG) && r_busy[iss_rs1] && !w_byp1;
    assign w_haz2    = (iss_rs2 != ZERO_REG) && r_busy[iss_rs2] && !w_byp2;
    assign op_rdata1 = w_byp1 ? r_rf_wdata : rf_rdata1;
    assign op_rdata2 = w_byp2 ? r_rf_wdata : rf_rdata2;
`else
    assign w_haz1    = (iss_rs1 != ZERO_REG) && r_busy[iss_rs1];
    assign w_haz2    = (iss_rs2 != ZERO_REG) && r_busy[iss_rs2];
    assign op_rdata1 = rf_rdata1;
    assign op_rdata2 = rf_rdata2;
`endif

    // WAW check stays on the raw busy bit even when bypassing.
    assign iss_stall = iss_valid && (w_haz1 || w_haz2 || (iss_we && r_busy[iss_rd]));

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration model plus a queue of expected writes.
module tb_rf_wb_scheduler;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] RD1 = 32'h1111_0001;
    localparam logic [31:0] RD2 = 32'h2222_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_we, iss_stall;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_waddr, wb1_waddr, rf_waddr;
    logic [31:0] wb0_wdata, wb1_wdata, rf_wdata;
    logic        rf_we;
    logic [31:0] rf_rdata1, rf_rdata2, op_rdata1, op_rdata2;

    rf_wb_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_we    (iss_we),
        .iss_stall (iss_stall),
        .wb0_valid (wb0_valid),
        .wb0_waddr (wb0_waddr),
        .wb0_wdata (wb0_wdata),
        .wb0_ready (wb0_ready),
        .wb1_valid (wb1_valid),
        .wb1_waddr (wb1_waddr),
        .wb1_wdata (wb1_wdata),
        .wb1_ready (wb1_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .op_rdata1 (op_rdata1),
        .op_rdata2 (op_rdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic        m_ptr  = 1'b0;
    logic        exp_stall;
    logic [31:0] exp_op1, exp_op2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: combinational checks at negedge, registered write checked after posedge.
    task automatic step(input string tag);
        exp_t e;
        logic g0, g1;
        @(negedge clk);
        g0 = wb0_valid && (!wb1_valid || !m_ptr);
        g1 = wb1_valid && (!wb0_valid || m_ptr);
        chk({tag, "/rdy0"}, wb0_ready, g0);
        chk({tag, "/rdy1"}, wb1_ready, g1);
        chk({tag, "/stall"}, iss_stall, exp_stall);
        chk({tag, "/op1"}, op_rdata1, exp_op1);
        chk({tag, "/op2"}, op_rdata2, exp_op2);
        e.we = 1'b0; e.a = '0; e.d = '0;
        if (g0) begin
            e.we = (wb0_waddr != 5'd0); e.a = wb0_waddr; e.d = wb0_wdata;
        end else if (g1) begin
            e.we = (wb1_waddr != 5'd0); e.a = wb1_waddr; e.d = wb1_wdata;
        end
        q.push_back(e);
        if (wb0_valid && wb1_valid) m_ptr = !m_ptr;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, "/rf_we"}, rf_we, e.we);
        if (e.we) begin
            chk({tag, "/rf_waddr"}, rf_waddr, e.a);
            chk({tag, "/rf_wdata"}, rf_wdata, e.d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iss_valid = 0; iss_we = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        wb0_valid = 0; wb0_waddr = 0; wb0_wdata = 0;
        wb1_valid = 0; wb1_waddr = 0; wb1_wdata = 0;
        rf_rdata1 = RD1; rf_rdata2 = RD2;
        exp_stall = 0; exp_op1 = RD1; exp_op2 = RD2;
        repeat (2) @(posedge clk);
        #1;
        chk("init/rf_we", rf_we, 1'b0);
        chk("init/rf_waddr", rf_waddr, 5'd0);
        chk("init/rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;

        // Single source
        wb0_valid = 1; wb0_waddr = 5'd5; wb0_wdata = 32'hDEAD_BEEF;
        step("single");
        wb0_valid = 0;

        // Contention: winner gets a fresh request each accept, loser holds
        wb0_valid = 1; wb0_waddr = 5'd10; wb0_wdata = $urandom;
        wb1_valid = 1; wb1_waddr = 5'd20; wb1_wdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("cont%0d", i));
            if (i % 2 == 0) begin
                wb0_waddr = wb0_waddr + 5'd1; wb0_wdata = $urandom;
            end else begin
                wb1_waddr = wb1_waddr + 5'd1; wb1_wdata = $urandom;
            end
        end
        wb0_valid = 0; wb1_valid = 0;

        // Write to x0 is accepted but never reaches the regfile
        wb1_valid = 1; wb1_waddr = 5'd0; wb1_wdata = 32'h5555_5555;
        step("wb_x0");
        wb1_valid = 0;

        // Scoreboard RAW/WAW on x7
        iss_valid = 1; iss_we = 1; iss_rd = 5'd7;
        step("iss_x7");
        iss_we = 0; iss_rd = 0; iss_rs1 = 5'd7; exp_stall = 1;
        step("raw_x7");
        iss_we = 1; iss_rd = 5'd7; iss_rs1 = 0;
        step("waw_x7");
        iss_we = 0; iss_rd = 0; iss_rs1 = 5'd7;
        wb0_valid = 1; wb0_waddr = 5'd7; wb0_wdata = 32'h0000_0077;
        step("wb_x7");
        wb0_valid = 0;
        exp_stall = !BYP; exp_op1 = BYP ? 32'h0000_0077 : RD1;
        step("commit_x7");
        exp_stall = 0; exp_op1 = RD1;
        step("after_x7");
        iss_valid = 0; iss_rs1 = 0;

        // Operand bypass on rs2
        wb1_valid = 1; wb1_waddr = 5'd9; wb1_wdata = 32'h0000_1234; iss_rs2 = 5'd9;
        step("byp_wr");
        wb1_valid = 0; exp_op2 = BYP ? 32'h0000_1234 : RD2;
        step("byp_rd");
        iss_rs2 = 0; exp_op2 = RD2;

        // rd = x0 never stalls or marks busy
        iss_valid = 1; iss_we = 1; iss_rd = 0;
        step("rd_x0");
        iss_we = 0; iss_rs1 = 0; iss_rs2 = 0;
        step("rs_x0");
        iss_valid = 0;

        // Issue x3 in the cycle x3 commits: busy must survive
        wb0_valid = 1; wb0_waddr = 5'd3; wb0_wdata = 32'h0000_0033;
        step("wb_x3");
        wb0_valid = 0; iss_valid = 1; iss_we = 1; iss_rd = 5'd3;
        step("iss_x3_commit");
        iss_we = 0; iss_rd = 0; iss_rs1 = 5'd3; exp_stall = 1;
        step("x3_still_busy");
        iss_valid = 0; iss_rs1 = 0; exp_stall = 0;

        // Reset mid-stream: drop in-flight write, clear busy, re-favour wb0
        wb0_valid = 1; wb0_waddr = 5'd12; wb0_wdata = 32'hC0C0_0012;
        wb1_valid = 1; wb1_waddr = 5'd13; wb1_wdata = 32'hD0D0_0013;
        step("pre_rst");
        wb0_waddr = 5'd14; wb0_wdata = 32'hC0C0_0014;
        rst_n = 1'b0;
        #1;
        chk("rst/rf_we", rf_we, 1'b0);
        chk("rst/rf_waddr", rf_waddr, 5'd0);
        chk("rst/rf_wdata", rf_wdata, 32'd0);
        iss_valid = 1; iss_rs1 = 5'd3;
        #1;
        chk("rst/busy_clr", iss_stall, 1'b0);
        @(posedge clk);
        #1;
        chk("rst/hold_we", rf_we, 1'b0);
        q.delete();
        m_ptr = 1'b0;
        rst_n = 1'b1;
        iss_valid = 0; iss_rs1 = 0;
        step("post_rst");
        wb0_valid = 0;
        step("post_rst2");
        wb1_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
